// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode/funct constants, ALU control encoding and engine state for alu_exec_unit
package alu_pkg;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] J      = 6'h02;
    localparam logic [5:0] JAL    = 6'h03;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] ADDIU  = 6'h09;
    localparam logic [5:0] SLTI   = 6'h0A;
    localparam logic [5:0] SLTIU  = 6'h0B;
    localparam logic [5:0] ANDI   = 6'h0C;
    localparam logic [5:0] ORI    = 6'h0D;
    localparam logic [5:0] XORI   = 6'h0E;
    localparam logic [5:0] LUI    = 6'h0F;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2B;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic [4:0] {
        ALU_NOP   = 5'd0,
        ALU_ADD   = 5'd1,
        ALU_ADDU  = 5'd2,
        ALU_SUB   = 5'd3,
        ALU_SUBU  = 5'd4,
        ALU_AND   = 5'd5,
        ALU_OR    = 5'd6,
        ALU_XOR   = 5'd7,
        ALU_NOR   = 5'd8,
        ALU_SLT   = 5'd9,
        ALU_SLTU  = 5'd10,
        ALU_SLL   = 5'd11,
        ALU_SRL   = 5'd12,
        ALU_SRA   = 5'd13,
        ALU_SLLV  = 5'd14,
        ALU_SRLV  = 5'd15,
        ALU_SRAV  = 5'd16,
        ALU_LUI   = 5'd17,
        ALU_MFHI  = 5'd18,
        ALU_MFLO  = 5'd19,
        ALU_MTHI  = 5'd20,
        ALU_MTLO  = 5'd21,
        ALU_MULT  = 5'd22,
        ALU_MULTU = 5'd23,
        ALU_DIV   = 5'd24,
        ALU_DIVU  = 5'd25
    } aluctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_exec_unit_div_iter.sv
// rtl/alu_exec_unit_div_iter.sv - restoring unsigned divider, one quotient bit per cycle
module div_iter #(
    parameter int WIDTH = 32,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(ITERS);

    logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
    logic [WIDTH-1:0] quo_nxt, rem_nxt;
    logic [WIDTH:0]   shifted, diff;
    logic [CW-1:0]    cnt;
    logic             fits;

    // quotient register doubles as the dividend shift-out register
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign fits    = ~diff[WIDTH];
    assign rem_nxt = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_nxt = {quo_q[WIDTH-2:0], fits};

    assign done      = busy && (cnt == CW'(ITERS - 1));
    assign quotient  = quo_nxt;
    assign remainder = rem_nxt;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (busy) begin
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
            cnt   <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU with HI/LO and MULT/DIV engine; ALU_OVERFLOW_TRAP_EN adds ovf_o
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_CYCLES  = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic [4:0]       sa,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       aluctrl_o,
    output logic             stall_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
`ifdef ALU_OVERFLOW_TRAP_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int CW = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;

    aluctrl_t         ctrl;
    state_t           st;
    logic [WIDTH-1:0] hi, lo, opa, opb, sum, dif, mag_a, mag_b, q_raw, r_raw;
    logic [2*WIDTH-1:0] ext_a, ext_b, product;
    logic [CW-1:0]    cnt;
    logic             sgn, is_mul, is_div, issue, kill, mul_last, div_done, div_busy;

    always_comb begin
        ctrl = ALU_NOP;
        case (op)
            R_TYPE: begin
                case (funct)
                    F_ADD:   ctrl = ALU_ADD;
                    F_ADDU:  ctrl = ALU_ADDU;
                    F_SUB:   ctrl = ALU_SUB;
                    F_SUBU:  ctrl = ALU_SUBU;
                    F_AND:   ctrl = ALU_AND;
                    F_OR:    ctrl = ALU_OR;
                    F_XOR:   ctrl = ALU_XOR;
                    F_NOR:   ctrl = ALU_NOR;
                    F_SLT:   ctrl = ALU_SLT;
                    F_SLTU:  ctrl = ALU_SLTU;
                    F_SLL:   ctrl = ALU_SLL;
                    F_SRL:   ctrl = ALU_SRL;
                    F_SRA:   ctrl = ALU_SRA;
                    F_SLLV:  ctrl = ALU_SLLV;
                    F_SRLV:  ctrl = ALU_SRLV;
                    F_SRAV:  ctrl = ALU_SRAV;
                    F_MFHI:  ctrl = ALU_MFHI;
                    F_MFLO:  ctrl = ALU_MFLO;
                    F_MTHI:  ctrl = ALU_MTHI;
                    F_MTLO:  ctrl = ALU_MTLO;
                    F_MULT:  ctrl = ALU_MULT;
                    F_MULTU: ctrl = ALU_MULTU;
                    F_DIV:   ctrl = ALU_DIV;
                    F_DIVU:  ctrl = ALU_DIVU;
                    default: ctrl = ALU_NOP;
                endcase
            end
            ADDI, ADDIU, LW, SW, J, JAL: ctrl = ALU_ADD;
            BEQ, BNE:                    ctrl = ALU_SUB;
            ANDI:                        ctrl = ALU_AND;
            ORI:                         ctrl = ALU_OR;
            XORI:                        ctrl = ALU_XOR;
            SLTI:                        ctrl = ALU_SLT;
            SLTIU:                       ctrl = ALU_SLTU;
            LUI:                         ctrl = ALU_LUI;
            default:                     ctrl = ALU_NOP;
        endcase
    end

    assign sum = a + b;
    assign dif = a - b;

    always_comb begin
        result_o = '0;
        case (ctrl)
            ALU_ADD, ALU_ADDU: result_o = sum;
            ALU_SUB, ALU_SUBU: result_o = dif;
            ALU_AND:  result_o = a & b;
            ALU_OR:   result_o = a | b;
            ALU_XOR:  result_o = a ^ b;
            ALU_NOR:  result_o = ~(a | b);
            ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: result_o = {{(WIDTH-1){1'b0}}, a < b};
            ALU_SLL:  result_o = b << sa;
            ALU_SRL:  result_o = b >> sa;
            ALU_SRA:  result_o = $signed(b) >>> sa;
            ALU_SLLV: result_o = b << a[4:0];
            ALU_SRLV: result_o = b >> a[4:0];
            ALU_SRAV: result_o = $signed(b) >>> a[4:0];
            ALU_LUI:  result_o = WIDTH'({b[15:0], 16'h0000});
            ALU_MFHI: result_o = hi;
            ALU_MFLO: result_o = lo;
            default:  result_o = '0;
        endcase
    end

`ifdef ALU_OVERFLOW_TRAP_EN
    logic chk_ovf;
    assign chk_ovf = (op == R_TYPE && (funct == F_ADD || funct == F_SUB)) || op == ADDI;
    assign ovf_o   = chk_ovf && ((ctrl == ALU_SUB)
                   ? ((a[WIDTH-1] ^ b[WIDTH-1]) & (dif[WIDTH-1] ^ a[WIDTH-1]))
                   : (~(a[WIDTH-1] ^ b[WIDTH-1]) & (sum[WIDTH-1] ^ a[WIDTH-1])));
`endif

    assign is_mul   = (ctrl == ALU_MULT) || (ctrl == ALU_MULTU);
    assign is_div   = (ctrl == ALU_DIV) || (ctrl == ALU_DIVU);
    assign issue    = valid_i && (st == IDLE) && (is_mul || is_div);
    assign kill     = rst || flush_i;
    assign mul_last = (st == MUL) && (cnt <= CW'(1));
    assign stall_o  = !kill && (issue || ((st == MUL) && !mul_last)
                                      || ((st == DIV) && !div_done));

    assign ext_a   = sgn ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
    assign ext_b   = sgn ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
    assign product = ext_a * ext_b;

    // divider sees magnitudes; signs are reapplied from the latched operands at writeback
    assign mag_a = (ctrl == ALU_DIV && a[WIDTH-1]) ? -a : a;
    assign mag_b = (ctrl == ALU_DIV && b[WIDTH-1]) ? -b : b;

    div_iter #(
        .WIDTH(WIDTH),
        .ITERS(DIV_CYCLES)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (issue && is_div && !kill),
        .abort    (kill),
        .dividend (mag_a),
        .divisor  (mag_b),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (q_raw),
        .remainder(r_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= IDLE;
            hi  <= '0;
            lo  <= '0;
            cnt <= '0;
            sgn <= 1'b0;
            opa <= '0;
            opb <= '0;
        end else if (flush_i) begin
            st <= IDLE;
        end else begin
            case (st)
                IDLE: begin
                    if (issue) begin
                        st  <= is_mul ? MUL : DIV;
                        cnt <= CW'(MUL_LATENCY - 1);
                        sgn <= (ctrl == ALU_MULT) || (ctrl == ALU_DIV);
                        opa <= a;
                        opb <= b;
                    end else if (valid_i && ctrl == ALU_MTHI) begin
                        hi <= a;
                    end else if (valid_i && ctrl == ALU_MTLO) begin
                        lo <= a;
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        {hi, lo} <= product;
                        st       <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DIV: begin
                    if (div_done || !div_busy) begin
                        st <= IDLE;
                    end
                    if (div_done) begin
                        if (opb == '0) begin
                            lo <= '1;
                            hi <= opa;
                        end else begin
                            lo <= (sgn && (opa[WIDTH-1] ^ opb[WIDTH-1])) ? -q_raw : q_raw;
                            hi <= (sgn && opa[WIDTH-1]) ? -r_raw : r_raw;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign aluctrl_o = ctrl;
    assign hi_o      = hi;
    assign lo_o      = lo;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - randomized self-checking bench for alu_exec_unit against a reference model
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, valid_i, flush_i;
    logic [5:0]   op, funct;
    logic [4:0]   sa;
    logic [W-1:0] a, b, result_o, hi_o, lo_o;
    logic [4:0]   aluctrl_o;
    logic         stall_o;
`ifdef ALU_OVERFLOW_TRAP_EN
    logic         ovf_o;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] m_hi, m_lo;
    logic [32:0] e;
    logic [5:0]  iops [14] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                               6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0]  mdf  [4]  = '{6'h18, 6'h19, 6'h1A, 6'h1B};

    alu_exec_unit #(.WIDTH(W), .MUL_LATENCY(2), .DIV_CYCLES(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .flush_i  (flush_i),
        .op       (op),
        .funct    (funct),
        .sa       (sa),
        .a        (a),
        .b        (b),
        .result_o (result_o),
        .aluctrl_o(aluctrl_o),
        .stall_o  (stall_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
`ifdef ALU_OVERFLOW_TRAP_EN
        ,
        .ovf_o    (ovf_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // shifts as multiply/divide by powers of two; arithmetic right shift as floor division
    function automatic logic [31:0] shl(input logic [31:0] y, input logic [4:0] s);
        logic [31:0] pw = 32'd1 << s;
        return y * pw;
    endfunction
    function automatic logic [31:0] shr(input logic [31:0] y, input logic [4:0] s);
        logic [31:0] pw = 32'd1 << s;
        return y / pw;
    endfunction
    function automatic logic [31:0] sar(input logic [31:0] y, input logic [4:0] s);
        logic [31:0] pw = 32'd1 << s;
        return y[31] ? ~((~y) / pw) : y / pw;
    endfunction

    // bit 32 = instruction is recognised, bits 31:0 = expected result
    function automatic logic [32:0] model(input logic [5:0] o, input logic [5:0] f, input logic [4:0] s,
                                          input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] h, input logic [31:0] l);
        logic [31:0] r = '0;
        logic        k = 1'b1;
        if (o == 6'h00) begin
            case (f)
                6'h20, 6'h21: r = x + y;
                6'h22, 6'h23: r = x - y;
                6'h24: r = x & y;
                6'h25: r = x | y;
                6'h26: r = x ^ y;
                6'h27: r = ~(x | y);
                6'h2A: r = (longint'($signed(x)) < longint'($signed(y))) ? 32'd1 : 32'd0;
                6'h2B: r = (longint'(x) < longint'(y)) ? 32'd1 : 32'd0;
                6'h00: r = shl(y, s);
                6'h02: r = shr(y, s);
                6'h03: r = sar(y, s);
                6'h04: r = shl(y, x[4:0]);
                6'h06: r = shr(y, x[4:0]);
                6'h07: r = sar(y, x[4:0]);
                6'h10: r = h;
                6'h12: r = l;
                6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: r = '0;
                default: k = 1'b0;
            endcase
        end else begin
            case (o)
                6'h08, 6'h09, 6'h23, 6'h2B, 6'h02, 6'h03: r = x + y;
                6'h04, 6'h05: r = x - y;
                6'h0C: r = x & y;
                6'h0D: r = x | y;
                6'h0E: r = x ^ y;
                6'h0A: r = (longint'($signed(x)) < longint'($signed(y))) ? 32'd1 : 32'd0;
                6'h0B: r = (longint'(x) < longint'(y)) ? 32'd1 : 32'd0;
                6'h0F: r = {y[15:0], 16'h0000};
                default: k = 1'b0;
            endcase
        end
        return {k, r};
    endfunction

    task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        logic [31:0] eh, el;
        longint      q, r;
        int          n, exp_n;
        bit          ok;
        case (f)
            6'h18: begin p = 64'(longint'($signed(x)) * longint'($signed(y))); eh = p[63:32]; el = p[31:0]; end
            6'h19: begin p = 64'(x) * 64'(y); eh = p[63:32]; el = p[31:0]; end
            6'h1A: begin
                if (y == 0) begin el = '1; eh = x; end
                else begin
                    q = longint'($signed(x)) / longint'($signed(y));
                    r = longint'($signed(x)) % longint'($signed(y));
                    el = q[31:0]; eh = r[31:0];
                end
            end
            default: begin
                if (y == 0) begin el = '1; eh = x; end
                else begin el = x / y; eh = x % y; end
            end
        endcase
        exp_n = (f == 6'h18 || f == 6'h19) ? 1 : W;
        valid_i = 1'b1; op = 6'h00; funct = f; a = x; b = y; flush_i = 1'b0;
        #2;
        check({tag, "_stall_issue"}, stall_o, 1);
        n = 1;
        tick();
        valid_i = 1'b0; a = $urandom; b = $urandom; funct = 6'h25;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            #2;
            if (!stall_o) begin
                ok = 1;
                break;
            end
            n++;
            tick();
        end
        check({tag, "_stall_len"}, ok ? n : 9999, exp_n);
        tick();
        #2;
        check({tag, "_hi"}, hi_o, eh);
        check({tag, "_lo"}, lo_o, el);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
        op = 6'h00; funct = 6'h20; sa = '0; a = 32'd5; b = 32'd3;
        tick();
        tick();
        #2;
        check("rst_result", result_o, 32'd8);
        rst = 1'b0;
        tick();
        #2;
        check("rst_hi", hi_o, 0);
        check("rst_lo", lo_o, 0);
        check("rst_stall", stall_o, 0);
        m_hi = '0;
        m_lo = '0;

        funct = 6'h25; a = 32'h0000F0F0; b = 32'h00FF00FF;
        #2;
        check("or_res", result_o, 32'h00FFF0FF);
        check("or_ctrl", aluctrl_o, ALU_OR);
        check("or_stall", stall_o, 0);
        tick();
        funct = 6'h03; sa = 5'd4; b = 32'h80000000;
        #2;
        check("sra_res", result_o, 32'hF8000000);
        funct = 6'h2B; a = 32'd1; b = 32'hFFFFFFFF;
        #2;
        check("sltu_res", result_o, 1);
        funct = 6'h2A;
        #2;
        check("slt_res", result_o, 0);
        tick();

        run_md("mult", 6'h18, -32'sd3, 32'd7);
        check("mult_hi_const", hi_o, 32'hFFFFFFFF);
        check("mult_lo_const", lo_o, 32'hFFFFFFEB);
        run_md("div", 6'h1A, -32'sd7, 32'd2);
        check("div_lo_const", lo_o, 32'hFFFFFFFD);
        check("div_hi_const", hi_o, 32'hFFFFFFFF);
        run_md("divu0", 6'h1B, 32'd7, 32'd0);
        check("divu0_lo_const", lo_o, 32'hFFFFFFFF);
        check("divu0_hi_const", hi_o, 32'd7);
        run_md("div_min", 6'h1A, 32'h80000000, 32'hFFFFFFFF);
        run_md("divs0", 6'h1A, -32'sd9, 32'd0);

        valid_i = 1'b1; op = 6'h00; funct = 6'h11; a = 32'h11;
        tick();
        funct = 6'h13; a = 32'h22;
        tick();
        m_hi = 32'h11; m_lo = 32'h22;
        funct = 6'h1B; a = 32'd1000; b = 32'd3;
        #2;
        check("flush_issue_stall", stall_o, 1);
        tick();
        valid_i = 1'b0;
        repeat (10) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #2;
        check("flush_stall", stall_o, 0);
        check("flush_hi", hi_o, 32'h11);
        check("flush_lo", lo_o, 32'h22);
        valid_i = 1'b1; funct = 6'h12;
        #2;
        check("flush_mflo", result_o, 32'h22);
        tick();
        valid_i = 1'b0;
        tick();
        #2;
        check("flush_idle_stall", stall_o, 0);
        check("flush_idle_lo", lo_o, 32'h22);

        valid_i = 1'b1; funct = 6'h11; a = 32'h55;
        tick();
        funct = 6'h18; a = 32'd5; b = 32'd6;
        tick();
        valid_i = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        check("rstmid_hi", hi_o, 0);
        check("rstmid_lo", lo_o, 0);
        check("rstmid_stall", stall_o, 0);
        m_hi = '0; m_lo = '0;
        valid_i = 1'b1; funct = 6'h3F;
        #2;
        check("unk_res", result_o, 0);
        check("unk_ctrl", aluctrl_o, 0);
        tick();
        valid_i = 1'b0;

`ifdef ALU_OVERFLOW_TRAP_EN
        funct = 6'h20; a = 32'h7FFFFFFF; b = 32'd1;
        #2;
        check("add_ovf", ovf_o, 1);
        check("add_ovf_res", result_o, 32'h80000000);
        funct = 6'h21;
        #2;
        check("addu_ovf", ovf_o, 0);
        tick();
`endif

        for (int i = 0; i < 24; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            case ($urandom % 4)
                0: y = '0;
                1: y = $urandom % 16;
                default: y = $urandom;
            endcase
            run_md("rnd_md", mdf[$urandom % 4], x, y);
        end

        for (int i = 0; i < 200; i++) begin
            int sel = $urandom % 4;
            valid_i = 1'($urandom % 2);
            flush_i = 1'b0;
            if (sel < 2) begin
                op = 6'h00;
            end else if (sel == 2) begin
                op = iops[$urandom % 14];
            end else begin
                op = 6'($urandom % 64);
            end
            funct = 6'($urandom % 64);
            if (op == 6'h00 && (funct == 6'h11 || funct == 6'h13 || (funct >= 6'h18 && funct <= 6'h1B)))
                funct = 6'h25;
            a = $urandom; b = $urandom; sa = 5'($urandom % 32);
            #2;
            e = model(op, funct, sa, a, b, m_hi, m_lo);
            check("rnd_res", result_o, e[31:0]);
            check("rnd_known", aluctrl_o != 5'd0, e[32]);
            check("rnd_stall", stall_o, 0);
`ifdef ALU_OVERFLOW_TRAP_EN
            begin
                longint s;
                logic   ov = 1'b0;
                if ((op == 6'h00 && funct == 6'h20) || op == 6'h08) begin
                    s = longint'($signed(a)) + longint'($signed(b));
                    ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                end else if (op == 6'h00 && funct == 6'h22) begin
                    s = longint'($signed(a)) - longint'($signed(b));
                    ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                end
                check("rnd_ovf", ovf_o, ov);
            end
`endif
            tick();
        end
        valid_i = 1'b0;
        #2;
        check("end_hi", hi_o, m_hi);
        check("end_lo", lo_o, m_lo);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
